// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin arbiter plus UART frame serialiser. One of NUM_REQ byte
//   requesters is granted per frame. Each granted byte is sent as start bit,
//   8 data bits LSB first, optional parity bit and stop bit. Every bit is held
//   baud_div+1 clock cycles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   baud_div            bit period minus one (latched per frame)
//   parity_en           1 = add parity bit (latched per frame)
//   parity_odd          1 = odd parity, 0 = even (latched per frame)
//   req_valid/req_data  per-requester byte offer, byte i at [8i+7:8i]
//   req_ready           one-hot accept strobe, combinational, IDLE only
//   txd                 serial output, idle high
//   busy                frame in flight (and inter-frame gap, if enabled)
//   grant_id            requester owning the current or last frame
//   frame_done          pulse in the last cycle of the stop bit
//
// Build option
//   UART_TX_SCHED_GAP_EN : after each frame, insert an extra idle-high gap of
//                          one bit period before the next arbitration.
module uart_tx_scheduler #(
  parameter int  NUM_REQ = 4,
  parameter int  DIV_W   = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   txd,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   frame_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef UART_TX_SCHED_GAP_EN
  localparam logic [1:0] ST_GAP  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [7:0]       data_q, data_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             par_en_q, par_en_d;
  logic             par_odd_q, par_odd_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;

  logic             found;
  logic [ID_W-1:0]  win_idx;
  logic [3:0]       last_bit;
  logic             parity;

  // Round-robin search: first valid requester at or after rr_q, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned cand;
      cand = 32'(rr_q) + k;
      if (cand >= 32'(NUM_REQ)) cand = cand - 32'(NUM_REQ);
      if (!found && req_valid[ID_W'(cand)]) begin
        found   = 1'b1;
        win_idx = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && found && !rst) req_ready[win_idx] = 1'b1;
  end

  assign last_bit   = par_en_q ? 4'd10 : 4'd9;
  assign parity     = (^data_q) ^ par_odd_q;
  assign frame_done = (state_q == ST_SEND) && (cnt_q == '0) && (bit_q == last_bit);

  // Bit index 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop.
  always_comb begin
    txd = 1'b1;
    if (state_q == ST_SEND) begin
      case (bit_q)
        4'd0:                                   txd = 1'b0;
        4'd1, 4'd2, 4'd3, 4'd4,
        4'd5, 4'd6, 4'd7, 4'd8:                 txd = data_q[3'(bit_q - 4'd1)];
        4'd9:                                   txd = par_en_q ? parity : 1'b1;
        default:                                txd = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    data_d    = data_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d   = ST_SEND;
          grant_d   = win_idx;
          rr_d      = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          busy_d    = 1'b1;
          data_d    = req_data[{win_idx, 3'b000} +: 8];
          div_d     = baud_div;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
          cnt_d     = baud_div;
          bit_d     = '0;
        end
      end
      ST_SEND: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bit_q == last_bit) begin
`ifdef UART_TX_SCHED_GAP_EN
          state_d = ST_GAP;
          cnt_d   = div_q;
`else
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`endif
        end else begin
          bit_d = bit_q + 4'd1;
          cnt_d = div_q;
        end
      end
`ifdef UART_TX_SCHED_GAP_EN
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
    end
  end

  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (NUM_REQ=4, DIV_W=16).
// Inputs change just after the falling edge; outputs are checked 1 time unit
// later, well away from the rising edge.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        txd;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  logic [10:0] vec;

  uart_tx_scheduler #(.NUM_REQ(4), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .txd        (txd),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; baud_div = '0; parity_en = 1'b0; parity_odd = 1'b0;
    req_valid = '0; req_data = '0;
    nxt(); nxt(); #1;
    chk("rst_txd",   32'(txd), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_fd",    32'(frame_done), 32'd0);
    rst = 1'b0;
    nxt(); #1;
    chk("idle_txd", 32'(txd), 32'd1);

    // Test 1: requester 2 sends 0xA5, D=4, even parity
    baud_div = 16'd3; parity_en = 1'b1; parity_odd = 1'b0;
    req_data[23:16] = 8'hA5; req_valid = 4'b0100; #1;
    chk("t1_ready", 32'(req_ready), 32'h4);
    vec = 11'b10101001010;
    for (int n = 0; n < 44; n++) begin
      nxt();
      if (n == 0) req_valid = '0;
      #1;
      chk("t1_txd",  32'(txd), 32'(vec[n/4]));
      chk("t1_fd",   32'(frame_done), 32'(n == 43));
      chk("t1_busy", 32'(busy), 32'd1);
    end
    chk("t1_grant", 32'(grant_id), 32'd2);
    nxt(); #1;
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_txd_end",  32'(txd), 32'd1);

    // Test 2: round robin from reset, all valid, D=1, parity on
    rst = 1'b1;
    nxt();
    rst = 1'b0; baud_div = 16'd0; parity_en = 1'b1;
    req_data = 32'h44332211; req_valid = 4'b1111; #1;
    for (int g = 0; g < 5; g++) begin
      chk("t2_ready", 32'(req_ready), 32'(1) << (g % 4));
      chk("t2_busy_idle", 32'(busy), 32'd0);
      if (g > 0) chk("t2_grant", 32'(grant_id), 32'((g - 1) % 4));
      for (int n = 0; n < 11; n++) begin
        nxt();
        if (g == 4 && n == 0) req_valid = '0;
        #1;
        chk("t2_ready_send", 32'(req_ready), 32'd0);
        if (n == 0) chk("t2_start", 32'(txd), 32'd0);
        chk("t2_fd", 32'(frame_done), 32'(n == 10));
      end
      nxt(); #1;
    end
    chk("t2_grant_last", 32'(grant_id), 32'd0);
    chk("t2_busy_end",   32'(busy), 32'd0);

    // Test 3: no parity, byte 0x00, D=2, requester 1 (pointer now 1)
    parity_en = 1'b0; baud_div = 16'd1;
    req_data[15:8] = 8'h00; req_valid = 4'b0010; #1;
    chk("t3_ready", 32'(req_ready), 32'h2);
    for (int n = 0; n < 20; n++) begin
      nxt();
      if (n == 0) req_valid = '0;
      #1;
      chk("t3_txd", 32'(txd), 32'(n >= 18));
      chk("t3_fd",  32'(frame_done), 32'(n == 19));
    end
    nxt(); #1;
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_grant",    32'(grant_id), 32'd1);

    // Test 4: odd parity, byte 0x01, D=3; inputs changed mid-frame
    parity_en = 1'b1; parity_odd = 1'b1; baud_div = 16'd2;
    req_data[31:24] = 8'h01; req_valid = 4'b1000; #1;
    chk("t4_ready", 32'(req_ready), 32'h8);
    vec = 11'b10000000010;
    for (int n = 0; n < 33; n++) begin
      nxt();
      if (n == 0) req_valid = '0;
      if (n == 5) begin baud_div = 16'd7; parity_odd = 1'b0; parity_en = 1'b0; end
      #1;
      chk("t4_txd", 32'(txd), 32'(vec[n/3]));
      chk("t4_fd",  32'(frame_done), 32'(n == 32));
    end
    nxt(); #1;
    chk("t4_busy_end", 32'(busy), 32'd0);
    chk("t4_grant",    32'(grant_id), 32'd3);

    // Test 5: reset during data bit 4 (pointer now 0, requester 2 wins)
    baud_div = 16'd1; parity_en = 1'b1; parity_odd = 1'b0;
    req_data[23:16] = 8'h3C; req_valid = 4'b0100; #1;
    chk("t5_ready", 32'(req_ready), 32'h4);
    for (int n = 0; n < 10; n++) begin
      nxt();
      if (n == 0) req_valid = '0;
      #1;
      chk("t5_busy", 32'(busy), 32'd1);
    end
    nxt(); #1;
    chk("t5_bit4", 32'(txd), 32'd1);
    chk("t5_grant_pre", 32'(grant_id), 32'd2);
    rst = 1'b1;
    nxt(); #1;
    chk("t5_txd_rst",   32'(txd), 32'd1);
    chk("t5_busy_rst",  32'(busy), 32'd0);
    chk("t5_fd_rst",    32'(frame_done), 32'd0);
    chk("t5_grant_rst", 32'(grant_id), 32'd0);
    rst = 1'b0; baud_div = 16'd0; req_valid = 4'b1111; #1;
    chk("t5_ready_after", 32'(req_ready), 32'h1);
    for (int n = 0; n < 11; n++) begin
      nxt();
      if (n == 0) req_valid = '0;
      #1;
      chk("t5_fd", 32'(frame_done), 32'(n == 10));
    end
    nxt(); #1;
    chk("t5_grant_after", 32'(grant_id), 32'd0);
    chk("t5_busy_end",    32'(busy), 32'd0);

    // Test 6: two queued bytes back to back, D=3 (pointer now 1)
    baud_div = 16'd2; parity_en = 1'b1;
    req_valid = 4'b0110; #1;
    chk("t6_ready1", 32'(req_ready), 32'h2);
    for (int n = 0; n < 33; n++) begin
      nxt();
      if (n == 0) req_valid = 4'b0100;
      #1;
      chk("t6_ready_send", 32'(req_ready), 32'd0);
      chk("t6_fd", 32'(frame_done), 32'(n == 32));
    end
`ifdef UART_TX_SCHED_GAP_EN
    for (int n = 0; n < 3; n++) begin
      nxt(); #1;
      chk("t6_gap_txd",   32'(txd), 32'd1);
      chk("t6_gap_busy",  32'(busy), 32'd1);
      chk("t6_gap_ready", 32'(req_ready), 32'd0);
    end
`endif
    nxt(); #1;
    chk("t6_idle_txd",  32'(txd), 32'd1);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_ready2",    32'(req_ready), 32'h4);
    for (int n = 0; n < 33; n++) begin
      nxt();
      if (n == 0) req_valid = '0;
      #1;
      if (n == 0) chk("t6_start2", 32'(txd), 32'd0);
      chk("t6_fd2", 32'(frame_done), 32'(n == 32));
    end
`ifdef UART_TX_SCHED_GAP_EN
    for (int n = 0; n < 3; n++) begin
      nxt(); #1;
    end
`endif
    nxt(); #1;
    chk("t6_grant",    32'(grant_id), 32'd2);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART serial transmit line between NUM_REQ byte requesters using round-robin arbitration.
- For each granted byte: builds the frame (start, 8 data LSB-first, optional parity, stop), times each bit with a programmable baud divider, and drives txd.
- Sits between the byte-producing clients and the pad. It is the sequencer for the frame-serialising datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DIV_W, 16, width of the baud divider input.
- ID_W, $clog2(NUM_REQ), width of grant_id (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- baud_div  in  DIV_W  bit period minus one, in clk cycles
- parity_en  in  1  1 = 11-bit frame with parity; 0 = 10-bit frame
- parity_odd  in  1  1 = odd parity, 0 = even parity
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*8  byte of requester i at [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot accept strobe
- txd  out  1  serial output, idle high
- busy  out  1  high while a frame is in flight
- grant_id  out  ID_W  index of requester owning the current or last frame
- frame_done  out  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values: txd=1, busy=0, req_ready=0, grant_id=0, frame_done=0. State=IDLE, RR pointer=0.
- States: IDLE, SEND, plus GAP when the optional feature is compiled in.
- IDLE:
  - Search starts at the RR pointer and wraps modulo NUM_REQ; the first i with req_valid[i]=1 wins.
  - req_ready[i]=1 for the winner only, combinationally in the same cycle. req_ready is all zero in every other state.
  - Transfer = req_valid[i] & req_ready[i] in cycle C. In that cycle the block latches req_data[i], baud_div, parity_en and parity_odd.
  - At edge C+1: grant_id<=i, RR pointer<=(i+1) mod NUM_REQ, busy<=1, state->SEND.
  - No valid requester: stay in IDLE, txd=1.
- SEND:
  - Start bit (0) appears on txd from cycle C+1.
  - Each bit is held D = latched baud_div+1 cycles. A down-counter reloads to latched baud_div at each bit boundary.
  - Bit order: start 0; data[0]..data[7]; parity if parity_en; stop 1.
  - Parity bit = ^data XOR parity_odd.
  - Frame length: 11*D cycles with parity, 10*D without.
  - frame_done=1 in the final cycle of the stop bit. Next state is IDLE (or GAP). busy drops on the same edge.
- Width and wrap rules:
  - baud_div=0 gives D=1, one bit per clk.
  - Maximum D = 2^DIV_W; the counter uses DIV_W bits, so there is no overflow.
  - Bit index counter is 4 bits and saturates at the last bit; it is never incremented past the stop bit.
- Requester contract: hold req_valid and req_data stable until req_ready. Dropping valid before ready is legal; that request is then not served.
- Simultaneous events:
  - Valid asserted by several requesters: only the RR winner is accepted.
  - A requester that just won gets the lowest priority for the next arbitration.
- Mid-frame input changes: changes to baud_div or parity inputs have no effect until the next transfer.
- Back-to-back frames: the stop bit lasts D cycles plus the 1-cycle IDLE arbitration cycle (txd=1), so the effective stop is D+1.
- Reset mid-frame: at the next edge txd=1, busy=0, RR pointer=0, and the in-flight byte is discarded with no frame_done.

Optional Feature:
- Macro: UART_TX_SCHED_GAP_EN.
- Defined:
  - After frame_done the FSM enters GAP for exactly D cycles (D latched for the finished frame) with txd=1 and req_ready=0.
  - It then returns to IDLE, guaranteeing at least 2 stop periods between frames.
  - busy stays high during GAP.
- Undefined: no GAP state; SEND goes directly to IDLE.

Test Plan:
- Single byte, baud_div=3, parity_en=1, parity_odd=0, requester 2 sends 0xA5:
  - Required response: txd = 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles. Total 44 cycles.
  - grant_id=2; frame_done high in cycle 44 after the transfer.
- Round-robin: all 4 req_valid held high, baud_div=0:
  - Required response: accept order 0,1,2,3,0. Exactly one req_ready bit per IDLE cycle.
  - Back-to-back spacing between start bits = 12 cycles.
- No parity: parity_en=0, byte 0x00, baud_div=1:
  - Required response: 9 zero bits (start plus 8 data), then a stop bit of 1.
  - Frame length 20 cycles.
- Odd parity: byte 0x01, parity_odd=1:
  - Required response: parity bit = 0.
  - Change baud_div from 2 to 7 mid-frame: all bits remain 3 cycles.
- Reset mid-frame: assert rst during data bit 4:
  - Required response: next cycle txd=1, busy=0, no frame_done.
  - The next grant with all requesters valid goes to requester 0.
- With UART_TX_SCHED_GAP_EN, baud_div=2, two queued bytes:
  - Required response: txd high for 3 (GAP) + 1 (IDLE) cycles between the stop bit and the next start bit.
  - req_ready stays 0 during GAP.
